// File: rtl/nios2_pio_pulse_out.sv
// nios2_pio_pulse_out: Avalon-MM output port with atomic bit set/clear
// writes and an optional one-shot pulse generator.
// Optional feature macro: PIO_PULSE_EN (PULSE / PULSE_LEN / STATUS registers).
// When PIO_PULSE_EN is undefined the block is a plain DATA/OUTSET/OUTCLEAR port.
module nios2_pio_pulse_out #(
  parameter int unsigned               DATA_WIDTH      = 8,
  parameter logic [DATA_WIDTH-1:0]     RESET_VALUE     = '0,
  parameter int unsigned               PULSE_LEN_RESET = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign wd          = writedata[DATA_WIDTH-1:0];
  assign unused_bits = ^writedata;

  // Data register: full replace, atomic set and atomic clear
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        3'd0:    data_out <= wd;
        3'd1:    data_out <= data_out | wd;
        3'd2:    data_out <= data_out & ~wd;
        default: data_out <= data_out;
      endcase
    end
  end

`ifdef PIO_PULSE_EN
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] pulse_mask, mask_next;
  logic [15:0]           count, count_next;
  logic [15:0]           pulse_len;
  logic [15:0]           len_eff;
  logic                  pulse_wr;
  logic                  busy;

  assign len_eff  = (pulse_len == 16'd0) ? 16'd1 : pulse_len;
  assign pulse_wr = wr_en && (address == 3'd3) && (wd != '0);
  assign busy     = (state == ACTIVE);

  // Pulse length register; a running pulse keeps its already-loaded count
  always_ff @(posedge clk) begin
    if (reset) begin
      pulse_len <= 16'(PULSE_LEN_RESET);
    end else if (wr_en && (address == 3'd4)) begin
      pulse_len <= writedata[15:0];
    end
  end

  // Pulse FSM state, mask and countdown registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pulse_mask <= '0;
      count      <= '0;
    end else begin
      state      <= state_next;
      pulse_mask <= mask_next;
      count      <= count_next;
    end
  end

  // Pulse FSM next-state: trigger, retrigger (merge or replace at expiry), countdown
  always_comb begin
    state_next = state;
    mask_next  = pulse_mask;
    count_next = count;
    case (state)
      IDLE: begin
        if (pulse_wr) begin
          state_next = ACTIVE;
          mask_next  = wd;
          count_next = len_eff;
        end
      end
      ACTIVE: begin
        if (pulse_wr) begin
          count_next = len_eff;
          // At expiry the old bits would drop this edge, so only the new bits survive
          mask_next  = (count == 16'd1) ? wd : (pulse_mask | wd);
        end else if (count == 16'd1) begin
          state_next = IDLE;
          mask_next  = '0;
          count_next = '0;
        end else begin
          count_next = count - 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        mask_next  = '0;
        count_next = '0;
      end
    endcase
  end

  assign out_port = data_out | pulse_mask;

  // Read mux: zero-extended, combinational, zero wait states
  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata = 32'(data_out);
      3'd3:    readdata = 32'(pulse_mask);
      3'd4:    readdata = {16'd0, pulse_len};
      3'd5:    readdata = {31'd0, busy};
      default: readdata = '0;
    endcase
  end
`else
  assign out_port = data_out;

  // Read mux: only DATA is readable without the pulse generator
  always_comb begin
    readdata = '0;
    if (address == 3'd0) begin
      readdata = 32'(data_out);
    end
  end
`endif

endmodule

// File: tb/tb_nios2_pio_pulse_out.sv
// Directed self-checking bench for nios2_pio_pulse_out (DATA_WIDTH=8, RESET_VALUE=8'hA5).
// Pulse-generator steps are only run when PIO_PULSE_EN is defined.
module tb_nios2_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int unsigned total = 0;
  int unsigned bad   = 0;

  nios2_pio_pulse_out #(
    .DATA_WIDTH      (8),
    .RESET_VALUE     (8'hA5),
    .PULSE_LEN_RESET (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; write is sampled at the next posedge, returns at the following negedge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic out_chk(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, out_port}, {24'd0, exp});
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    out_chk("reset_out", 8'hA5);
    rd_chk("reset_rd0", 3'd0, 32'hA5);
`ifdef PIO_PULSE_EN
    rd_chk("reset_rd4", 3'd4, 32'd4);
`else
    rd_chk("reset_rd4", 3'd4, 32'd0);
`endif
    rd_chk("reset_rd5", 3'd5, 32'd0);
    rd_chk("reset_rd3", 3'd3, 32'd0);

    // Set / clear
    wr(3'd0, 32'h0F);
    out_chk("data_0f", 8'h0F);
    wr(3'd1, 32'hF0);
    out_chk("set_f0", 8'hFF);
    wr(3'd2, 32'h81);
    out_chk("clr_81", 8'h7E);
    rd_chk("rd_outset", 3'd1, 32'd0);
    rd_chk("rd_outclr", 3'd2, 32'd0);
    rd_chk("rd_data", 3'd0, 32'h7E);
    wr(3'd0, 32'hFFFF_FF00);
    out_chk("upper_ignored", 8'h00);
    rd_chk("rd_upper", 3'd0, 32'h0);
    wr(3'd6, 32'hFF);
    out_chk("addr6_wr", 8'h00);
    rd_chk("rd_addr6", 3'd6, 32'd0);
    rd_chk("rd_addr7", 3'd7, 32'd0);

`ifdef PIO_PULSE_EN
    // Pulse length 3
    wr(3'd4, 32'd3);
    rd_chk("rd_len3", 3'd4, 32'd3);
    wr(3'd3, 32'h01);
    rd_chk("rd_mask", 3'd3, 32'h01);
    for (int i = 0; i < 3; i++) begin
      address = 3'd5;
      #1;
      out_chk($sformatf("len3_out%0d", i), 8'h01);
      chk($sformatf("len3_busy%0d", i), readdata, 32'd1);
      @(negedge clk);
    end
    out_chk("len3_end", 8'h00);
    rd_chk("len3_idle", 3'd5, 32'd0);

    // Pulse length 0 behaves as 1
    wr(3'd4, 32'd0);
    rd_chk("rd_len0", 3'd4, 32'd0);
    wr(3'd3, 32'h01);
    out_chk("len0_out", 8'h01);
    rd_chk("len0_busy", 3'd5, 32'd1);
    @(negedge clk);
    out_chk("len0_end", 8'h00);
    rd_chk("len0_idle", 3'd5, 32'd0);

    // Zero-data PULSE write is ignored
    wr(3'd3, 32'h0000_0100);
    out_chk("zero_pulse", 8'h00);
    rd_chk("zero_busy", 3'd5, 32'd0);

    // Retrigger merges bits and reloads the count
    wr(3'd4, 32'd5);
    wr(3'd3, 32'h01);
    out_chk("rt_a0", 8'h01);
    @(negedge clk);
    out_chk("rt_a1", 8'h01);
    wr(3'd3, 32'h02);
    rd_chk("rt_mask", 3'd3, 32'h03);
    for (int i = 0; i < 5; i++) begin
      out_chk($sformatf("rt_b%0d", i), 8'h03);
      @(negedge clk);
    end
    out_chk("rt_end", 8'h00);

    // Retrigger exactly at expiry replaces the mask
    wr(3'd4, 32'd3);
    wr(3'd3, 32'h01);
    out_chk("exp_a0", 8'h01);
    @(negedge clk);
    out_chk("exp_a1", 8'h01);
    @(negedge clk);
    out_chk("exp_a2", 8'h01);
    wr(3'd3, 32'h04);
    for (int i = 0; i < 3; i++) begin
      out_chk($sformatf("exp_b%0d", i), 8'h04);
      @(negedge clk);
    end
    out_chk("exp_end", 8'h00);

    // Data and pulse combine on the port
    wr(3'd0, 32'h80);
    wr(3'd4, 32'd2);
    wr(3'd3, 32'h81);
    out_chk("mix_on", 8'h81);
    // PULSE_LEN write while active leaves the running count alone
    wr(3'd4, 32'd5);
    out_chk("mix_on2", 8'h81);
    @(negedge clk);
    out_chk("mix_end", 8'h80);
    rd_chk("rd_len5", 3'd4, 32'd5);
    wr(3'd0, 32'h00);

    // Reset mid-pulse, with a simultaneous write that must lose
    wr(3'd4, 32'd100);
    wr(3'd3, 32'hFF);
    repeat (9) @(negedge clk);
    out_chk("long_on", 8'hFF);
    reset      = 1'b1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h33;
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    out_chk("mid_reset_out", 8'hA5);
    rd_chk("mid_reset_busy", 3'd5, 32'd0);
    rd_chk("mid_reset_len", 3'd4, 32'd4);
`else
    // Pulse registers absent
    wr(3'd3, 32'hFF);
    out_chk("nopulse_out", 8'h00);
    rd_chk("nopulse_rd3", 3'd3, 32'd0);
    wr(3'd4, 32'd7);
    rd_chk("nopulse_rd4", 3'd4, 32'd0);
    rd_chk("nopulse_rd5", 3'd5, 32'd0);
    // Reset with simultaneous write
    reset      = 1'b1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = 3'd0;
    writedata  = 32'h33;
    @(negedge clk);
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    out_chk("reset_prio", 8'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
